// File: rtl/dmi_jtag_tap_sync_if.sv
// DMI request/response channel between the JTAG DTM (master) and the debug module (slave).
interface dmi_jtag_tap_sync_if #(
    parameter int AbitsWidth = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic [AbitsWidth-1:0] req_addr;
    logic [31:0]           req_data;
    logic [1:0]            req_op;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [1:0]            resp_resp;

    modport master (output req_valid, req_addr, req_data, req_op, resp_ready,
                    input  req_ready, resp_valid, resp_data, resp_resp);
    modport slave  (input  req_valid, req_addr, req_data, req_op, resp_ready,
                    output req_ready, resp_valid, resp_data, resp_resp);
endinterface

// File: rtl/dmi_jtag_tap_sync.sv
// JTAG DTM running entirely in the clk_i domain: oversampled TAP, IDCODE/DTMCS/DMI/BYPASS DRs,
// DMI valid/ready bridge. Define JTAG_IDCODE_EN to implement the IDCODE instruction.
module dmi_jtag_tap_sync #(
    parameter logic [31:0] IdcodeValue = 32'h0000_0DB3,
    parameter int          AbitsWidth  = 7,
    parameter int          IrLength    = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    input  logic                trst_ni,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    dmi_jtag_tap_sync_if.master dmi
);
    localparam int DrWidth = AbitsWidth + 34;
    localparam logic [IrLength-1:0] IrDtmcs = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IrDmi   = IrLength'(5'h11);
`ifdef JTAG_IDCODE_EN
    localparam logic [IrLength-1:0] IrIdcode  = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IrDefault = IrLength'(5'h01);
`else
    localparam logic [IrLength-1:0] IrDefault = IrLength'(5'h1F);
`endif

    typedef enum logic [3:0] {
        TAP_TLR = 4'd0, TAP_RTI = 4'd1, TAP_SEL_DR = 4'd2, TAP_CAP_DR = 4'd3,
        TAP_SH_DR = 4'd4, TAP_EX1_DR = 4'd5, TAP_PA_DR = 4'd6, TAP_EX2_DR = 4'd7,
        TAP_UPD_DR = 4'd8, TAP_SEL_IR = 4'd9, TAP_CAP_IR = 4'd10, TAP_SH_IR = 4'd11,
        TAP_EX1_IR = 4'd12, TAP_PA_IR = 4'd13, TAP_EX2_IR = 4'd14, TAP_UPD_IR = 4'd15
    } tap_state_e;
    typedef enum logic [1:0] {DR_BYPASS = 2'd0, DR_IDCODE = 2'd1, DR_DTMCS = 2'd2, DR_DMI = 2'd3} dr_sel_e;
    typedef enum logic [1:0] {DMI_IDLE = 2'd0, DMI_REQ = 2'd1, DMI_RESP = 2'd2} dmi_state_e;

    logic [3:0]            meta_r, sync_r;  // {trst_n, tdi, tms, tck}
    logic                  tck_q_r, tck_rise_s, tck_fall_s, tms_s, tdi_s, trst_n_s;
    tap_state_e            tap_r, tap_nxt_s;
    logic [IrLength-1:0]   ir_r, ir_shift_r;
    dr_sel_e               dr_sel_s;
    logic [DrWidth-1:0]    dr_shift_r, dr_cap_s, dr_shifted_s;
    logic                  tdo_r, tdo_oe_r;
    dmi_state_e            dmi_r, dmi_nxt_s;
    logic                  req_valid_r, resp_ready_r;
    logic [AbitsWidth-1:0] req_addr_r;
    logic [31:0]           req_data_r, last_data_r, last_data_nxt_s;
    logic [1:0]            req_op_r, sticky_r, sticky_nxt_s, sticky_resp_s, cap_status_s;
    logic                  cap_dr_s, sh_dr_s, upd_dr_s, cap_ir_s, sh_ir_s, upd_ir_s;
    logic                  resp_fire_s, busy_nxt_s, op_valid_s, dmi_upd_s, dmi_go_s, dmi_busy_hit_s;
    logic                  dtmcs_upd_s, hard_s, clr_s, cap_busy_s;

    // Two-flop synchronisers on the JTAG pins plus TCK history for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_r  <= 4'b0000;
            sync_r  <= 4'b0000;
            tck_q_r <= 1'b0;
        end else begin
            meta_r  <= {trst_ni, tdi_i, tms_i, tck_i};
            sync_r  <= meta_r;
            tck_q_r <= sync_r[0];
        end
    end

    assign tck_rise_s = sync_r[0] & ~tck_q_r;
    assign tck_fall_s = ~sync_r[0] & tck_q_r;
    assign tms_s      = sync_r[1];
    assign tdi_s      = sync_r[2];
    assign trst_n_s   = sync_r[3];

    // IEEE 1149.1 TAP next-state function.
    always_comb begin
        tap_nxt_s = tap_r;
        case (tap_r)
            TAP_TLR:    tap_nxt_s = tms_s ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    tap_nxt_s = tms_s ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: tap_nxt_s = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: tap_nxt_s = tms_s ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  tap_nxt_s = tms_s ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: tap_nxt_s = tms_s ? TAP_UPD_DR : TAP_PA_DR;
            TAP_PA_DR:  tap_nxt_s = tms_s ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: tap_nxt_s = tms_s ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: tap_nxt_s = tms_s ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: tap_nxt_s = tms_s ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: tap_nxt_s = tms_s ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  tap_nxt_s = tms_s ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: tap_nxt_s = tms_s ? TAP_UPD_IR : TAP_PA_IR;
            TAP_PA_IR:  tap_nxt_s = tms_s ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: tap_nxt_s = tms_s ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: tap_nxt_s = tms_s ? TAP_SEL_DR : TAP_RTI;
            default:    tap_nxt_s = TAP_TLR;
        endcase
    end

    assign cap_dr_s = tck_rise_s && trst_n_s && (tap_r == TAP_CAP_DR);
    assign sh_dr_s  = tck_rise_s && trst_n_s && (tap_r == TAP_SH_DR);
    assign upd_dr_s = tck_fall_s && trst_n_s && (tap_r == TAP_UPD_DR);
    assign cap_ir_s = tck_rise_s && trst_n_s && (tap_r == TAP_CAP_IR);
    assign sh_ir_s  = tck_rise_s && trst_n_s && (tap_r == TAP_SH_IR);
    assign upd_ir_s = tck_fall_s && trst_n_s && (tap_r == TAP_UPD_IR);

    // Unrecognised instructions fall through to BYPASS.
    always_comb begin
        dr_sel_s = DR_BYPASS;
        case (ir_r)
`ifdef JTAG_IDCODE_EN
            IrIdcode: dr_sel_s = DR_IDCODE;
`endif
            IrDtmcs:  dr_sel_s = DR_DTMCS;
            IrDmi:    dr_sel_s = DR_DMI;
            default:  dr_sel_s = DR_BYPASS;
        endcase
    end

    // DMI bookkeeping; a response landing in the same cycle as Capture-DR is folded in first.
    assign resp_fire_s     = resp_ready_r & dmi.resp_valid;
    assign busy_nxt_s      = (dmi_r != DMI_IDLE) && !resp_fire_s;
    assign last_data_nxt_s = (resp_fire_s && req_op_r == 2'd1) ? dmi.resp_data : last_data_r;
    assign sticky_resp_s   = (resp_fire_s && dmi.resp_resp == 2'd2 && sticky_r == 2'd0) ? 2'd2 : sticky_r;
    assign cap_status_s    = busy_nxt_s ? 2'd3 : sticky_resp_s;
    assign op_valid_s      = (dr_shift_r[1:0] == 2'd1) || (dr_shift_r[1:0] == 2'd2);
    assign dmi_upd_s       = upd_dr_s && (dr_sel_s == DR_DMI);
    assign dmi_go_s        = dmi_upd_s && op_valid_s && (dmi_r == DMI_IDLE) && (sticky_r == 2'd0);
    assign dmi_busy_hit_s  = dmi_upd_s && op_valid_s && (dmi_r != DMI_IDLE);
    assign dtmcs_upd_s     = upd_dr_s && (dr_sel_s == DR_DTMCS);
    assign hard_s          = dtmcs_upd_s && dr_shift_r[17];
    assign clr_s           = dtmcs_upd_s && (dr_shift_r[16] || dr_shift_r[17]);
    assign cap_busy_s      = cap_dr_s && (dr_sel_s == DR_DMI) && busy_nxt_s;

    // Capture values and the length-dependent shift of the selected DR.
    always_comb begin
        dr_cap_s = {DrWidth{1'b0}};
        case (dr_sel_s)
            DR_IDCODE: dr_cap_s = DrWidth'(IdcodeValue);
            DR_DTMCS:  dr_cap_s = DrWidth'({17'd0, 3'd1, sticky_r, 6'(AbitsWidth), 4'd1});
            DR_DMI:    dr_cap_s = {req_addr_r, last_data_nxt_s, cap_status_s};
            default:   dr_cap_s = {DrWidth{1'b0}};
        endcase
        dr_shifted_s = {1'b0, dr_shift_r[DrWidth-1:1]};
        case (dr_sel_s)
            DR_DMI:              dr_shifted_s[DrWidth-1] = tdi_s;
            DR_IDCODE, DR_DTMCS: dr_shifted_s[31] = tdi_s;
            default:             dr_shifted_s[0] = tdi_s;
        endcase
    end

    // TAP state, instruction path, data shift register and TDO.
    always_ff @(posedge clk_i) begin
        if (rst_i || !trst_n_s) tap_r <= TAP_TLR;
        else if (tck_rise_s)    tap_r <= tap_nxt_s;
        if (rst_i || !trst_n_s || tap_r == TAP_TLR) ir_r <= IrDefault;
        else if (upd_ir_s)                          ir_r <= ir_shift_r;
        if (rst_i) begin
            ir_shift_r <= IrDefault;
            dr_shift_r <= {DrWidth{1'b0}};
            tdo_r      <= 1'b0;
            tdo_oe_r   <= 1'b0;
        end else begin
            if (cap_ir_s)     ir_shift_r <= IrDefault;
            else if (sh_ir_s) ir_shift_r <= {tdi_s, ir_shift_r[IrLength-1:1]};
            if (cap_dr_s)     dr_shift_r <= dr_cap_s;
            else if (sh_dr_s) dr_shift_r <= dr_shifted_s;
            if (tck_fall_s && tap_r == TAP_SH_IR)      tdo_r <= ir_shift_r[0];
            else if (tck_fall_s && tap_r == TAP_SH_DR) tdo_r <= dr_shift_r[0];
            tdo_oe_r <= (tap_r == TAP_SH_IR) || (tap_r == TAP_SH_DR);
        end
    end

    // DMI transaction FSM: next state and sticky status.
    always_comb begin
        dmi_nxt_s = dmi_r;
        if (hard_s) begin
            dmi_nxt_s = DMI_IDLE;
        end else begin
            case (dmi_r)
                DMI_IDLE: dmi_nxt_s = dmi_go_s ? DMI_REQ : DMI_IDLE;
                DMI_REQ:  dmi_nxt_s = dmi.req_ready ? DMI_RESP : DMI_REQ;
                DMI_RESP: dmi_nxt_s = dmi.resp_valid ? DMI_IDLE : DMI_RESP;
                default:  dmi_nxt_s = DMI_IDLE;
            endcase
        end
        sticky_nxt_s = sticky_r;
        if (clr_s)                                sticky_nxt_s = 2'd0;
        else if (cap_busy_s || dmi_busy_hit_s)    sticky_nxt_s = 2'd3;
        else                                      sticky_nxt_s = sticky_resp_s;
    end

    // DMI state register and registered request/response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmi_r        <= DMI_IDLE;
            req_valid_r  <= 1'b0;
            resp_ready_r <= 1'b0;
            req_addr_r   <= {AbitsWidth{1'b0}};
            req_data_r   <= 32'h0000_0000;
            req_op_r     <= 2'd0;
            last_data_r  <= 32'h0000_0000;
            sticky_r     <= 2'd0;
        end else begin
            dmi_r        <= dmi_nxt_s;
            req_valid_r  <= (dmi_nxt_s == DMI_REQ);
            resp_ready_r <= (dmi_nxt_s == DMI_RESP);
            last_data_r  <= last_data_nxt_s;
            sticky_r     <= sticky_nxt_s;
            if (dmi_go_s) begin
                req_addr_r <= dr_shift_r[DrWidth-1 -: AbitsWidth];
                req_data_r <= dr_shift_r[33:2];
                req_op_r   <= dr_shift_r[1:0];
            end
        end
    end

    assign tdo_o          = tdo_r;
    assign tdo_oe_o       = tdo_oe_r;
    assign dmi.req_valid  = req_valid_r;
    assign dmi.req_addr   = req_addr_r;
    assign dmi.req_data   = req_data_r;
    assign dmi.req_op     = req_op_r;
    assign dmi.resp_ready = resp_ready_r;
endmodule

// File: tb/tb_dmi_jtag_tap_sync.sv
// Directed bench for dmi_jtag_tap_sync: bit-banged JTAG initiator plus a hand-driven DMI responder.
module tb_dmi_jtag_tap_sync;
    logic clk = 1'b0;
    logic rst, tck, tms, tdi, trst_n, tdo, tdo_oe;
    int   checks = 0;
    int   failures = 0;

    dmi_jtag_tap_sync_if #(.AbitsWidth(7)) dmi ();

    dmi_jtag_tap_sync #(.IdcodeValue(32'h0000_0DB3), .AbitsWidth(7), .IrLength(5)) dut (
        .clk_i(clk), .rst_i(rst), .tck_i(tck), .tms_i(tms), .tdi_i(tdi), .trst_ni(trst_n),
        .tdo_o(tdo), .tdo_oe_o(tdo_oe), .dmi(dmi)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One TCK period of 8 clk_i; TDO is sampled just before the rising edge.
    task automatic tck_pulse(input logic t_ms, input logic t_di, output logic t_do);
        tms = t_ms; tdi = t_di; t_do = tdo;
        tck = 1'b1; repeat (4) @(negedge clk);
        tck = 1'b0; repeat (4) @(negedge clk);
    endtask

    task automatic scan_ir(input logic [4:0] ir);
        logic d;
        tck_pulse(1'b1, 1'b0, d); tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d); tck_pulse(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) tck_pulse(i == 4, ir[i], d);
        tck_pulse(1'b1, 1'b0, d); tck_pulse(1'b0, 1'b0, d);
    endtask

    task automatic scan_dr(input logic [40:0] din, input int len, output logic [40:0] dout);
        logic d;
        dout = {41{1'b0}};
        tck_pulse(1'b1, 1'b0, d); tck_pulse(1'b0, 1'b0, d); tck_pulse(1'b0, 1'b0, d);
        for (int i = 0; i < len; i++) begin
            tck_pulse(i == len - 1, din[i], d);
            dout[i] = d;
        end
        tck_pulse(1'b1, 1'b0, d); tck_pulse(1'b0, 1'b0, d);
    endtask

    // Handshake the outstanding request and return one response.
    task automatic complete_txn(input logic [31:0] rdata, input logic [1:0] rresp);
        dmi.req_ready = 1'b1; @(negedge clk); dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b1; dmi.resp_data = rdata; dmi.resp_resp = rresp;
        @(negedge clk);
        dmi.resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trst_n = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
        dmi.req_ready = 1'b0; dmi.resp_valid = 1'b0; dmi.resp_data = 32'h0; dmi.resp_resp = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
        checks++; if (tdo_oe !== 1'b0) begin failures++; $display("FAIL reset_tdo_oe: got %b expected 0", tdo_oe); end
        checks++; if (dmi.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", dmi.req_valid); end
        checks++; if (dmi.resp_ready !== 1'b0) begin failures++; $display("FAIL reset_resp_ready: got %b expected 0", dmi.resp_ready); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idcode();
        logic [40:0] dout; logic [31:0] exp; logic d;
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, d);
        tck_pulse(1'b0, 1'b0, d);
        scan_dr(41'h000_A5A5_0F0F, 32, dout);
`ifdef JTAG_IDCODE_EN
        exp = 32'h0000_0DB3;
`else
        exp = 32'h4B4A_1E1E;
`endif
        checks++; if (dout[31:0] !== exp) begin failures++; $display("FAIL idcode_scan: got %h expected %h", dout[31:0], exp); end
        checks++; if (tdo_oe !== 1'b0) begin failures++; $display("FAIL oe_idle: got %b expected 0", tdo_oe); end
    endtask

    task automatic test_dtmcs();
        logic [40:0] dout;
        scan_ir(5'h10);
        scan_dr(41'h0, 32, dout);
        checks++; if (dout[31:0] !== 32'h0000_1071) begin failures++; $display("FAIL dtmcs_read: got %h expected 00001071", dout[31:0]); end
    endtask

    task automatic test_dmi_write();
        logic [40:0] dout; logic held;
        scan_ir(5'h11);
        dmi.req_ready = 1'b0;
        scan_dr({7'h10, 32'h0000_0001, 2'd2}, 41, dout);
        checks++; if (dout !== 41'h0) begin failures++; $display("FAIL write_capture: got %h expected 0", dout); end
        checks++; if ({dmi.req_valid, dmi.req_addr, dmi.req_data, dmi.req_op} !== {1'b1, 7'h10, 32'h0000_0001, 2'd2}) begin
            failures++; $display("FAIL write_req: got v=%b a=%h d=%h op=%0d expected v=1 a=10 d=00000001 op=2",
                                 dmi.req_valid, dmi.req_addr, dmi.req_data, dmi.req_op); end
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); held = held & dmi.req_valid; end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL write_valid_hold: got %b expected 1", held); end
        dmi.req_ready = 1'b1; @(negedge clk); dmi.req_ready = 1'b0;
        checks++; if (dmi.req_valid !== 1'b0) begin failures++; $display("FAIL write_valid_drop: got %b expected 0", dmi.req_valid); end
        checks++; if (dmi.resp_ready !== 1'b1) begin failures++; $display("FAIL write_resp_ready: got %b expected 1", dmi.resp_ready); end
        dmi.resp_valid = 1'b1; dmi.resp_data = 32'hFFFF_FFFF; dmi.resp_resp = 2'd0;
        @(negedge clk); dmi.resp_valid = 1'b0;
        checks++; if (dmi.resp_ready !== 1'b0) begin failures++; $display("FAIL write_resp_done: got %b expected 0", dmi.resp_ready); end
    endtask

    task automatic test_dmi_read();
        logic [40:0] dout;
        scan_dr({7'h11, 32'h0, 2'd1}, 41, dout);
        checks++; if (dout !== {7'h10, 32'h0, 2'd0}) begin failures++; $display("FAIL read_capture: got %h expected %h", dout, {7'h10, 32'h0, 2'd0}); end
        checks++; if ({dmi.req_valid, dmi.req_addr, dmi.req_op} !== {1'b1, 7'h11, 2'd1}) begin
            failures++; $display("FAIL read_req: got v=%b a=%h op=%0d expected v=1 a=11 op=1", dmi.req_valid, dmi.req_addr, dmi.req_op); end
        complete_txn(32'h0003_0C82, 2'd0);
        scan_dr(41'h0, 41, dout);
        checks++; if (dout !== {7'h11, 32'h0003_0C82, 2'd0}) begin failures++; $display("FAIL read_result: got %h expected %h", dout, {7'h11, 32'h0003_0C82, 2'd0}); end
        repeat (2) @(negedge clk);
        checks++; if (dmi.req_valid !== 1'b0) begin failures++; $display("FAIL nop_no_req: got %b expected 0", dmi.req_valid); end
    endtask

    task automatic test_busy_and_clear();
        logic [40:0] dout;
        dmi.req_ready = 1'b0;
        scan_dr({7'h05, 32'hDEAD_BEEF, 2'd2}, 41, dout);
        checks++; if (dout !== {7'h11, 32'h0003_0C82, 2'd0}) begin failures++; $display("FAIL busy_first_capture: got %h expected %h", dout, {7'h11, 32'h0003_0C82, 2'd0}); end
        scan_dr({7'h06, 32'h0000_1234, 2'd2}, 41, dout);
        checks++; if (dout !== {7'h05, 32'h0003_0C82, 2'd3}) begin failures++; $display("FAIL busy_capture: got %h expected %h", dout, {7'h05, 32'h0003_0C82, 2'd3}); end
        checks++; if ({dmi.req_valid, dmi.req_addr, dmi.req_data} !== {1'b1, 7'h05, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL busy_req_kept: got v=%b a=%h d=%h expected v=1 a=05 d=deadbeef", dmi.req_valid, dmi.req_addr, dmi.req_data); end
        complete_txn(32'h0, 2'd0);
        repeat (3) @(negedge clk);
        checks++; if (dmi.req_valid !== 1'b0) begin failures++; $display("FAIL busy_no_second: got %b expected 0", dmi.req_valid); end
        scan_dr(41'h0, 41, dout);
        checks++; if (dout[1:0] !== 2'd3) begin failures++; $display("FAIL sticky_busy: got %0d expected 3", dout[1:0]); end
        scan_ir(5'h10);
        scan_dr(41'h000_0001_0000, 32, dout);
        checks++; if (dout[31:0] !== 32'h0000_1C71) begin failures++; $display("FAIL dtmcs_busy: got %h expected 00001c71", dout[31:0]); end
        scan_ir(5'h11);
        scan_dr({7'h07, 32'h0000_0055, 2'd2}, 41, dout);
        checks++; if (dout !== {7'h05, 32'h0003_0C82, 2'd0}) begin failures++; $display("FAIL cleared_capture: got %h expected %h", dout, {7'h05, 32'h0003_0C82, 2'd0}); end
        checks++; if ({dmi.req_valid, dmi.req_addr, dmi.req_data} !== {1'b1, 7'h07, 32'h0000_0055}) begin
            failures++; $display("FAIL cleared_req: got v=%b a=%h d=%h expected v=1 a=07 d=00000055", dmi.req_valid, dmi.req_addr, dmi.req_data); end
        complete_txn(32'h0, 2'd0);
    endtask

    task automatic test_trst();
        logic [40:0] dout; logic [31:0] exp; logic d;
        tck_pulse(1'b1, 1'b0, d); tck_pulse(1'b0, 1'b0, d); tck_pulse(1'b0, 1'b0, d);
        for (int i = 0; i < 3; i++) tck_pulse(1'b0, 1'b1, d);
        checks++; if (tdo_oe !== 1'b1) begin failures++; $display("FAIL oe_shift: got %b expected 1", tdo_oe); end
        trst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (tdo_oe !== 1'b0) begin failures++; $display("FAIL trst_oe: got %b expected 0", tdo_oe); end
        trst_n = 1'b1;
        repeat (4) @(negedge clk);
        tck_pulse(1'b0, 1'b0, d);
        scan_dr(41'h000_A5A5_0F0F, 32, dout);
`ifdef JTAG_IDCODE_EN
        exp = 32'h0000_0DB3;
`else
        exp = 32'h4B4A_1E1E;
`endif
        checks++; if (dout[31:0] !== exp) begin failures++; $display("FAIL trst_ir_reset: got %h expected %h", dout[31:0], exp); end
    endtask

    task automatic test_rst_mid();
        logic [40:0] dout; logic [31:0] exp; logic d;
        scan_ir(5'h11);
        dmi.req_ready = 1'b0;
        scan_dr({7'h09, 32'h0000_ABCD, 2'd2}, 41, dout);
        checks++; if (dmi.req_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b expected 1", dmi.req_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({dmi.req_valid, dmi.resp_ready, tdo_oe} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_outputs: got %b expected 000", {dmi.req_valid, dmi.resp_ready, tdo_oe}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tck_pulse(1'b0, 1'b0, d);
        scan_dr(41'h000_A5A5_0F0F, 32, dout);
`ifdef JTAG_IDCODE_EN
        exp = 32'h0000_0DB3;
`else
        exp = 32'h4B4A_1E1E;
`endif
        checks++; if (dout[31:0] !== exp) begin failures++; $display("FAIL rst_ir_reset: got %h expected %h", dout[31:0], exp); end
        scan_ir(5'h11);
        scan_dr(41'h0, 41, dout);
        checks++; if (dout !== 41'h0) begin failures++; $display("FAIL rst_last_cleared: got %h expected 0", dout); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_dtmcs();
        test_dmi_write();
        test_dmi_read();
        test_busy_and_clear();
        test_trst();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
